// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: shared definitions for the program-counter / return-stack block.
//   cmd_e        - decoded per-cycle command, one value per priority level
//   DEF_*        - default parameter values (15-bit PC, 8-entry stack, reset to 0)
//   decode_cmd() - priority decoder: stall > ret > call > load > inc > hold
package pc_stack_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_STALL
  } cmd_e;

  localparam int unsigned DEF_ADDR_W    = 15;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_RESET_VEC = 0;

  function automatic cmd_e decode_cmd(input logic stall, input logic ret,
                                      input logic call, input logic load,
                                      input logic inc);
    if (stall)     return CMD_STALL;
    else if (ret)  return CMD_RET;
    else if (call) return CMD_CALL;
    else if (load) return CMD_LOAD;
    else if (inc)  return CMD_INC;
    else           return CMD_HOLD;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// ras_lifo: return-address stack (LIFO) with occupancy counter.
//   clk, reset_n : clock, async active-low reset (clears occupancy only)
//   push, wdata  : write wdata at the slot above the top; ignored when full
//   pop          : discard the top entry; ignored when empty; push wins if both
//   rdata        : current top entry (stack[depth-1]); meaningless when empty
//   depth        : occupancy 0..DEPTH
//   full, empty  : depth==DEPTH / depth==0, decoded from depth
module ras_lifo #(
  parameter int unsigned W     = 15,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Low bits of the count address the next free slot; when full they wrap
  // to 0 but the write is gated off by full.
  assign wr_idx = cnt[AW-1:0];
  assign rd_idx = cnt[AW-1:0] - AW'(1);
  assign rdata  = mem[rd_idx];
  assign depth  = cnt;
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);

  // Storage carries no reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with call/return address stack.
//   clk, reset_n          : clock, async active-low reset
//   stall                 : freeze everything (including err_clr) this cycle
//   inc / load / call / ret: pc+1 / pc<=data_in / push pc+1 & jump / pop into pc
//   data_in               : jump and call target
//   err_clr               : clear sticky overflow/underflow (errors this cycle win)
//   pc_out                : registered program counter
//   depth                 : stack occupancy 0..DEPTH
//   stack_full/stack_empty: decoded from depth
//   overflow/underflow    : sticky flags for call-when-full / ret-when-empty
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned        ADDR_W    = DEF_ADDR_W,
  parameter int unsigned        DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    inc,
  input  logic                    load,
  input  logic                    call,
  input  logic                    ret,
  input  logic [ADDR_W-1:0]       data_in,
  input  logic                    err_clr,
  output logic [ADDR_W-1:0]       pc_out,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    overflow,
  output logic                    underflow
);

  cmd_e              cmd;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [ADDR_W-1:0] top;
  logic              push;
  logic              pop;
  logic              ovf_evt;
  logic              unf_evt;

  always_comb begin
    cmd         = decode_cmd(stall, ret, call, load, inc);
    pc_next_seq = pc_out + ADDR_W'(1);
    push        = (cmd == CMD_CALL) && !stack_full;
    pop         = (cmd == CMD_RET)  && !stack_empty;
    ovf_evt     = (cmd == CMD_CALL) &&  stack_full;
    unf_evt     = (cmd == CMD_RET)  &&  stack_empty;
  end

  ras_lifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_next_seq),
    .rdata   (top),
    .depth   (depth),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out    <= RESET_VEC;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (cmd != CMD_STALL) begin
      unique case (cmd)
        CMD_INC:  pc_out <= pc_next_seq;
        CMD_LOAD: pc_out <= data_in;
        CMD_CALL: if (push) pc_out <= data_in;
        CMD_RET:  if (pop)  pc_out <= top;
        default:  pc_out <= pc_out;
      endcase
      // Clear first, then let this cycle's error event re-assert its flag.
      overflow  <= ovf_evt || (overflow  && !err_clr);
      underflow <= unf_evt || (underflow && !err_clr);
    end
  end

endmodule
